// File: rtl/fir_xifu_ex.sv
// fir_xifu_ex: FIR XIFU execute stage (load/store request, 2-lane dot product, ex2wb register).
// Define FIR_XIFU_DOTP_SAT_EN to saturate the dot-product accumulator instead of wrapping.
package fir_xifu_pkg;
    localparam int unsigned XIF_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        INSTR_INVALID = 2'd0,
        XFIRLW        = 2'd1,
        XFIRSW        = 2'd2,
        XFIRDOTP      = 2'd3
    } fir_xifu_instr_t;

    typedef struct packed {
        fir_xifu_instr_t         instr;
        logic [31:0]             base;
        logic [11:0]             offset;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic [XIF_ID_WIDTH-1:0] id;
    } fir_xifu_id2ex_t;
endpackage

module fir_xifu_ex
    import fir_xifu_pkg::*;
#(
    parameter int unsigned ID_WIDTH = XIF_ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                id2ex_valid_i,
    output logic                id2ex_ready_o,
    input  fir_xifu_id2ex_t     id2ex_i,
    output logic [4:0]          rf_raddr_a_o,
    output logic [4:0]          rf_raddr_b_o,
    input  logic [31:0]         rf_rdata_a_i,
    input  logic [31:0]         rf_rdata_b_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [31:0]         mem_addr_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [31:0]         mem_wdata_o,
    output logic [ID_WIDTH-1:0] mem_id_o,
    output logic                ex2wb_valid_o,
    input  logic                ex2wb_ready_i,
    output fir_xifu_instr_t     ex2wb_instr_o,
    output logic [4:0]          ex2wb_rd_o,
    output logic [ID_WIDTH-1:0] ex2wb_id_o,
    output logic                ex2wb_err_o,
    output logic [31:0]         acc_o
);

    typedef enum logic [1:0] {IDLE, MEM, DOTP, WB} state_e;

`ifdef FIR_XIFU_DOTP_SAT_EN
    localparam int unsigned SUM_W = 34;
`else
    localparam int unsigned SUM_W = 32;
`endif

    state_e                 state_q, state_d;
    fir_xifu_instr_t        instr_q;
    logic [4:0]             rd_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [31:0]            a_q, b_q, addr_q, addr_d;
    logic [31:0]            acc_q, acc_d;
    logic                   err_q;
    logic                   accept, is_mem_op, misaligned;
    logic signed [31:0]     prod_lo, prod_hi;
    logic signed [SUM_W-1:0] dotp_sum;

    assign rf_raddr_a_o  = id2ex_i.rs1;
    assign rf_raddr_b_o  = id2ex_i.rs2;
    assign addr_d        = id2ex_i.base + {{20{id2ex_i.offset[11]}}, id2ex_i.offset};
    assign is_mem_op     = (id2ex_i.instr == XFIRLW) || (id2ex_i.instr == XFIRSW);
    assign misaligned    = addr_d[1:0] != 2'b00;
    assign id2ex_ready_o = (state_q == IDLE) && !clear_i && !rst_i;
    assign accept        = id2ex_valid_i && id2ex_ready_o;

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (id2ex_i.instr)
                            XFIRLW, XFIRSW: state_d = misaligned ? WB : MEM;
                            XFIRDOTP:       state_d = DOTP;
                            default:        state_d = IDLE;
                        endcase
                    end
                end
                MEM:     if (mem_ready_i) state_d = WB;
                DOTP:    state_d = WB;
                WB:      if (ex2wb_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Sum width grows to 34 bits only when saturation needs to see the overflow.
    always_comb begin
        prod_lo  = 32'($signed(a_q[15:0])) * 32'($signed(b_q[15:0]));
        prod_hi  = 32'($signed(a_q[31:16])) * 32'($signed(b_q[31:16]));
        dotp_sum = SUM_W'($signed(acc_q)) + SUM_W'(prod_lo) + SUM_W'(prod_hi);
`ifdef FIR_XIFU_DOTP_SAT_EN
        if (dotp_sum[33:31] != {3{dotp_sum[33]}}) begin
            acc_d = dotp_sum[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            acc_d = dotp_sum[31:0];
        end
`else
        acc_d = dotp_sum[31:0];
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            instr_q <= INSTR_INVALID;
            rd_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= id2ex_i.instr;
                rd_q    <= id2ex_i.rd;
                id_q    <= ID_WIDTH'(id2ex_i.id);
                a_q     <= rf_rdata_a_i;
                b_q     <= rf_rdata_b_i;
                addr_q  <= addr_d;
                err_q   <= is_mem_op && misaligned;
            end
            if (clear_i) begin
                acc_q <= '0;
            end else if (state_q == DOTP) begin
                acc_q <= acc_d;
            end
        end
    end

    assign mem_valid_o   = state_q == MEM;
    assign mem_addr_o    = mem_valid_o ? addr_q : '0;
    assign mem_we_o      = mem_valid_o && (instr_q == XFIRSW);
    assign mem_be_o      = mem_valid_o ? 4'hF : 4'h0;
    assign mem_wdata_o   = mem_we_o ? b_q : '0;
    assign mem_id_o      = mem_valid_o ? id_q : '0;

    assign ex2wb_valid_o = state_q == WB;
    assign ex2wb_instr_o = ex2wb_valid_o ? instr_q : INSTR_INVALID;
    assign ex2wb_rd_o    = ex2wb_valid_o ? rd_q : '0;
    assign ex2wb_id_o    = ex2wb_valid_o ? id_q : '0;
    assign ex2wb_err_o   = ex2wb_valid_o && err_q;
    assign acc_o         = acc_q;

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Self-checking bench for fir_xifu_ex: transaction-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_fir_xifu_ex;
    import fir_xifu_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i, clear_i, id2ex_valid_i, mem_ready_i, ex2wb_ready_i;
    logic            id2ex_ready_o;
    fir_xifu_id2ex_t id2ex_i;
    logic [4:0]      rf_raddr_a_o, rf_raddr_b_o;
    logic [31:0]     rf_rdata_a_i, rf_rdata_b_i;
    logic            mem_valid_o, mem_we_o;
    logic [31:0]     mem_addr_o, mem_wdata_o;
    logic [3:0]      mem_be_o, mem_id_o;
    logic            ex2wb_valid_o, ex2wb_err_o;
    fir_xifu_instr_t ex2wb_instr_o;
    logic [4:0]      ex2wb_rd_o;
    logic [3:0]      ex2wb_id_o;
    logic [31:0]     acc_o;

    logic [31:0] rf [32];
    assign rf_rdata_a_i = rf[rf_raddr_a_o];
    assign rf_rdata_b_i = rf[rf_raddr_b_o];

    always #5 clk_i = ~clk_i;

    fir_xifu_ex #(.ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .id2ex_valid_i(id2ex_valid_i), .id2ex_ready_o(id2ex_ready_o), .id2ex_i(id2ex_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
        .ex2wb_valid_o(ex2wb_valid_o), .ex2wb_ready_i(ex2wb_ready_i), .ex2wb_instr_o(ex2wb_instr_o),
        .ex2wb_rd_o(ex2wb_rd_o), .ex2wb_id_o(ex2wb_id_o), .ex2wb_err_o(ex2wb_err_o), .acc_o(acc_o)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dotp_ref(input logic [31:0] acc, input logic [31:0] a,
                                             input logic [31:0] b);
        longint s;
        s = longint'($signed(acc))
          + longint'($signed(a[15:0])) * longint'($signed(b[15:0]))
          + longint'($signed(a[31:16])) * longint'($signed(b[31:16]));
`ifdef FIR_XIFU_DOTP_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // Reference model: one outstanding instruction, tracked as pending memory / dotp / result flags.
    bit              m_mem = 1'b0, m_dotp = 1'b0, m_wb = 1'b0;
    logic [31:0]     m_acc = '0, m_a, m_b, m_addr;
    fir_xifu_instr_t m_instr;
    logic [4:0]      m_rd;
    logic [3:0]      m_id;
    logic            m_err;
    int              n_acc = 0;
    logic [31:0]     in_addr;
    assign in_addr = id2ex_i.base + {{20{id2ex_i.offset[11]}}, id2ex_i.offset};

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_mem <= 1'b0; m_dotp <= 1'b0; m_wb <= 1'b0; m_acc <= '0;
        end else if (clear_i) begin
            m_mem <= 1'b0; m_dotp <= 1'b0; m_wb <= 1'b0; m_acc <= '0;
        end else if (m_wb) begin
            if (ex2wb_ready_i) m_wb <= 1'b0;
        end else if (m_mem) begin
            if (mem_ready_i) begin m_mem <= 1'b0; m_wb <= 1'b1; end
        end else if (m_dotp) begin
            m_acc <= dotp_ref(m_acc, m_a, m_b);
            m_dotp <= 1'b0;
            m_wb <= 1'b1;
        end else if (id2ex_valid_i) begin
            n_acc   <= n_acc + 1;
            m_instr <= id2ex_i.instr;
            m_rd    <= id2ex_i.rd;
            m_id    <= id2ex_i.id;
            m_a     <= rf[id2ex_i.rs1];
            m_b     <= rf[id2ex_i.rs2];
            m_addr  <= in_addr;
            m_err   <= 1'b0;
            if (id2ex_i.instr == XFIRLW || id2ex_i.instr == XFIRSW) begin
                if (in_addr[1:0] != 2'b00) begin m_err <= 1'b1; m_wb <= 1'b1; end
                else m_mem <= 1'b1;
            end else if (id2ex_i.instr == XFIRDOTP) begin
                m_dotp <= 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (cmp_en && !rst_i) begin
            check("raddr_a", 32'(rf_raddr_a_o), 32'(id2ex_i.rs1));
            check("raddr_b", 32'(rf_raddr_b_o), 32'(id2ex_i.rs2));
            check("id2ex_ready", 32'(id2ex_ready_o), 32'(!(m_mem || m_dotp || m_wb) && !clear_i));
            check("mem_valid", 32'(mem_valid_o), 32'(m_mem));
            if (m_mem) begin
                check("mem_addr", mem_addr_o, m_addr);
                check("mem_we", 32'(mem_we_o), 32'(m_instr == XFIRSW));
                check("mem_be", 32'(mem_be_o), 32'hF);
                check("mem_wdata", mem_wdata_o, (m_instr == XFIRSW) ? m_b : 32'h0);
                check("mem_id", 32'(mem_id_o), 32'(m_id));
            end
            check("ex2wb_valid", 32'(ex2wb_valid_o), 32'(m_wb));
            if (m_wb) begin
                check("wb_instr", 32'(ex2wb_instr_o), 32'(m_instr));
                check("wb_rd", 32'(ex2wb_rd_o), 32'(m_rd));
                check("wb_id", 32'(ex2wb_id_o), 32'(m_id));
                check("wb_err", 32'(ex2wb_err_o), 32'(m_err));
            end
            check("acc", acc_o, m_acc);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
        if (rand_rdy) begin
            mem_ready_i   = ($urandom_range(0, 1) == 1);
            ex2wb_ready_i = ($urandom_range(0, 2) != 0);
            clear_i       = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic send(input fir_xifu_instr_t ins, input logic [31:0] base, input logic [11:0] off,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [3:0] id);
        int start;
        bit done;
        @(posedge clk_i);
        #2;
        id2ex_i.instr = ins; id2ex_i.base = base; id2ex_i.offset = off;
        id2ex_i.rs1 = rs1; id2ex_i.rs2 = rs2; id2ex_i.rd = rd; id2ex_i.id = id;
        id2ex_valid_i = 1'b1;
        start = n_acc;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (n_acc != start) done = 1'b1;
        end
        id2ex_valid_i = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL accept_timeout got=no-accept exp=accept");
        end
    endtask

    task automatic wait_idle();
        bit idle;
        mem_ready_i = 1'b1;
        ex2wb_ready_i = 1'b1;
        idle = 1'b0;
        for (int k = 0; k < 100 && !idle; k++) begin
            step();
            idle = !(m_mem || m_dotp || m_wb);
        end
        if (!idle) begin
            checks++; failures++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk_i); #2; clear_i = 1'b1;
        @(posedge clk_i); #2; clear_i = 1'b0;
    endtask

    logic [31:0]     r_base, exp_sat;
    logic [11:0]     r_off;
    fir_xifu_instr_t r_ins;
    int              r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; id2ex_valid_i = 1'b0; id2ex_i = '0;
        mem_ready_i = 1'b0; ex2wb_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        repeat (2) @(negedge clk_i);
        check("rst_mem_valid", 32'(mem_valid_o), 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_ex2wb_valid", 32'(ex2wb_valid_o), 32'h0);
        check("rst_acc", acc_o, 32'h0);
        check("rst_id2ex_ready", 32'(id2ex_ready_o), 32'h0);
        @(posedge clk_i); #2; rst_i = 1'b0;
        cmp_en = 1'b1;

        // Load with base 0x1000, offset -4; memory accepts on the 4th request cycle.
        mem_ready_i = 1'b0;
        send(XFIRLW, 32'h1000, 12'hFFC, 5'd1, 5'd2, 5'd5, 4'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("lw_mem_valid", 32'(mem_valid_o), 32'h1);
            check("lw_mem_addr", mem_addr_o, 32'h0000_0FFC);
            check("lw_mem_we", 32'(mem_we_o), 32'h0);
            if (k == 3) mem_ready_i = 1'b1;
        end
        step();
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("lw_wb_valid", 32'(ex2wb_valid_o), 32'h1);
        check("lw_wb_rd", 32'(ex2wb_rd_o), 32'd5);
        check("lw_wb_id", 32'(ex2wb_id_o), 32'd3);
        wait_idle();

        // Misaligned store: result with error one cycle after accept, no request.
        send(XFIRSW, 32'h2002, 12'h000, 5'd1, 5'd2, 5'd6, 4'd4);
        @(negedge clk_i);
        check("sw_mis_wb_valid", 32'(ex2wb_valid_o), 32'h1);
        check("sw_mis_err", 32'(ex2wb_err_o), 32'h1);
        check("sw_mis_mem_valid", 32'(mem_valid_o), 32'h0);
        wait_idle();

        // Dot product 2*4 + 3*5 = 23, twice.
        pulse_clear();
        rf[3] = 32'h0002_0003; rf[4] = 32'h0004_0005;
        send(XFIRDOTP, 32'h0, 12'h0, 5'd3, 5'd4, 5'd7, 4'd9);
        @(negedge clk_i);
        check("dotp_n1_wb_valid", 32'(ex2wb_valid_o), 32'h0);
        @(negedge clk_i);
        check("dotp_acc23", acc_o, 32'd23);
        check("dotp_n2_wb_valid", 32'(ex2wb_valid_o), 32'h1);
        wait_idle();
        send(XFIRDOTP, 32'h0, 12'h0, 5'd3, 5'd4, 5'd7, 4'd9);
        wait_idle();
        check("dotp_acc46", acc_o, 32'd46);

        // Build acc = 0x7FFF0000, then add 2^31.
        pulse_clear();
        rf[6] = 32'h8000_7FFF; rf[7] = 32'h8000_7FFF;
        rf[8] = 32'h0000_FFFF; rf[9] = 32'h0000_0001;
        rf[10] = 32'h8000_8000; rf[11] = 32'h8000_8000;
        send(XFIRDOTP, 32'h0, 12'h0, 5'd6, 5'd7, 5'd1, 4'd1);
        wait_idle();
        send(XFIRDOTP, 32'h0, 12'h0, 5'd8, 5'd9, 5'd1, 4'd1);
        wait_idle();
        check("dotp_acc_7fff0000", acc_o, 32'h7FFF_0000);
        send(XFIRDOTP, 32'h0, 12'h0, 5'd10, 5'd11, 5'd1, 4'd1);
        wait_idle();
`ifdef FIR_XIFU_DOTP_SAT_EN
        exp_sat = 32'h7FFF_FFFF;
`else
        exp_sat = 32'hFFFF_0000;
`endif
        check("dotp_overflow", acc_o, exp_sat);

        // Writeback backpressure with a second entry waiting.
        ex2wb_ready_i = 1'b0;
        send(XFIRDOTP, 32'h0, 12'h0, 5'd3, 5'd4, 5'd7, 4'd9);
        id2ex_i.instr = XFIRLW; id2ex_i.base = 32'h40; id2ex_i.offset = 12'h004;
        id2ex_i.rs1 = 5'd2; id2ex_i.rs2 = 5'd3; id2ex_i.rd = 5'd11; id2ex_i.id = 4'd2;
        id2ex_valid_i = 1'b1;
        mem_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            check("bp_id2ex_ready", 32'(id2ex_ready_o), 32'h0);
            if (k >= 1) check("bp_wb_rd", 32'(ex2wb_rd_o), 32'd7);
        end
        ex2wb_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_ready", 32'(id2ex_ready_o), 32'h1);
        @(posedge clk_i); #2; id2ex_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_second_mem_valid", 32'(mem_valid_o), 32'h1);
        check("bp_second_addr", mem_addr_o, 32'h44);
        wait_idle();

        // Clear during a memory request with acc = 5.
        pulse_clear();
        rf[12] = 32'd1; rf[13] = 32'd5;
        send(XFIRDOTP, 32'h0, 12'h0, 5'd12, 5'd13, 5'd2, 4'd5);
        wait_idle();
        mem_ready_i = 1'b0;
        send(XFIRLW, 32'h100, 12'h000, 5'd1, 5'd2, 5'd3, 4'd6);
        @(negedge clk_i);
        check("clr_pre_mem_valid", 32'(mem_valid_o), 32'h1);
        check("clr_pre_acc", acc_o, 32'd5);
        @(posedge clk_i); #2; clear_i = 1'b1;
        @(posedge clk_i); #2; clear_i = 1'b0;
        @(negedge clk_i);
        check("clr_mem_valid", 32'(mem_valid_o), 32'h0);
        check("clr_acc", acc_o, 32'h0);
        check("clr_ready", 32'(id2ex_ready_o), 32'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("clr_no_wb", 32'(ex2wb_valid_o), 32'h0);
        end
        wait_idle();

        // Randomized traffic with random handshakes and occasional clears.
        rand_rdy = 1'b1;
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            r_ins = (r < 1) ? INSTR_INVALID : (r < 4) ? XFIRLW : (r < 7) ? XFIRSW : XFIRDOTP;
            r_base = $urandom;
            r_off = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) begin
                r_base[1:0] = 2'b00;
                r_off[1:0] = 2'b00;
            end
            rf[$urandom_range(0, 31)] = $urandom;
            send(r_ins, r_base, r_off, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rdy = 1'b0;
        clear_i = 1'b0;
        wait_idle();

        // Reset in the middle of a memory request.
        mem_ready_i = 1'b0;
        send(XFIRSW, 32'h200, 12'h008, 5'd4, 5'd5, 5'd1, 4'd7);
        @(negedge clk_i);
        check("rstmid_pre_valid", 32'(mem_valid_o), 32'h1);
        @(posedge clk_i); #2; rst_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_mem_valid", 32'(mem_valid_o), 32'h0);
        check("rstmid_acc", acc_o, 32'h0);
        @(posedge clk_i); #2; rst_i = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
